// File: rtl/decode_ctrl_stage.sv
// Registered MIPS decode/control stage: decodes one instruction into a control
// bundle, holds it in a single-entry valid/ready register, and interlocks HI/LO users.
module decode_ctrl_stage #(
    parameter logic ENABLE_MULDIV  = 1'b1,
    parameter int   MULDIV_LATENCY = 4,
    parameter int   CNT_W          = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] instr_in,
    input  logic        instr_valid_in,
    output logic        instr_ready_out,
    input  logic        ex_ready_in,
    input  logic        flush_in,
    output logic        ctrl_valid_out,
    output logic [15:0] ctrl_out,
    output logic [3:0]  mmask_out,
    output logic        illegal_out,
    output logic [31:0] instr_out,
    output logic        muldiv_busy_out
);

    localparam logic [15:0] C_REGDST   = 16'h0001;
    localparam logic [15:0] C_REGWRITE = 16'h0002;
    localparam logic [15:0] C_ALUSRC   = 16'h0004;
    localparam logic [15:0] C_BRANCH   = 16'h0008;
    localparam logic [15:0] C_JUMP     = 16'h0010;
    localparam logic [15:0] C_MEMREAD  = 16'h0020;
    localparam logic [15:0] C_MEMWRITE = 16'h0040;
    localparam logic [15:0] C_MEMTOREG = 16'h0080;
    localparam logic [15:0] C_ATOMIC   = 16'h0100;
    localparam logic [15:0] C_BEQ      = 16'h0200;
    localparam logic [15:0] C_JAL      = 16'h0400;
    localparam logic [15:0] C_JR       = 16'h0800;
    localparam logic [15:0] C_LUI      = 16'h1000;
    localparam logic [15:0] C_ZEROEXT  = 16'h2000;
    localparam logic [15:0] C_MULDIV   = 16'h4000;
    localparam logic [15:0] C_HILORD   = 16'h8000;

    localparam logic [15:0] C_LOAD  = C_REGWRITE | C_ALUSRC | C_MEMREAD | C_MEMTOREG;
    localparam logic [15:0] C_STORE = C_ALUSRC | C_MEMWRITE;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY);

    typedef struct packed {
        logic [15:0] ctrl;
        logic [3:0]  mask;
        logic        illegal;
    } dec_t;

    // Illegal encodings leave ctrl and mask at zero; only the illegal flag is raised.
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.ctrl    = 16'h0000;
        d.mask    = 4'h0;
        d.illegal = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h08: d.ctrl = C_JR;
                    6'h00, 6'h02, 6'h03,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b: d.ctrl = C_REGDST | C_REGWRITE;
                    6'h10, 6'h12: begin
                        if (ENABLE_MULDIV) d.ctrl = C_REGDST | C_REGWRITE | C_HILORD;
                        else               d.illegal = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (ENABLE_MULDIV) d.ctrl = C_MULDIV;
                        else               d.illegal = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: d.ctrl = C_REGWRITE | C_ALUSRC;
            6'h0c, 6'h0d: d.ctrl = C_REGWRITE | C_ALUSRC | C_ZEROEXT;
            6'h0f: begin
                d.ctrl = C_REGWRITE | C_ALUSRC | C_LUI;
                d.mask = 4'hf;
            end
            6'h04: d.ctrl = C_BRANCH | C_BEQ;
            6'h05: d.ctrl = C_BRANCH;
            6'h02: d.ctrl = C_JUMP;
            6'h03: d.ctrl = C_REGWRITE | C_JUMP | C_JAL;
            6'h23: begin
                d.ctrl = C_LOAD;
                d.mask = 4'hf;
            end
            6'h25: begin
                d.ctrl = C_LOAD;
                d.mask = 4'h3;
            end
            6'h24: begin
                d.ctrl = C_LOAD;
                d.mask = 4'h1;
            end
            6'h30: d.ctrl = C_LOAD;
            6'h2b: begin
                d.ctrl = C_STORE;
                d.mask = 4'hf;
            end
            6'h29: begin
                d.ctrl = C_STORE;
                d.mask = 4'h3;
            end
            6'h28: begin
                d.ctrl = C_STORE;
                d.mask = 4'h1;
            end
            6'h38: d.ctrl = C_REGWRITE | C_ALUSRC | C_MEMWRITE | C_ATOMIC;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    dec_t             in_dec_s;
    logic             busy_s;
    logic             hazard_s;
    logic             base_ready_s;
    logic             ready_s;
    logic             accept_s;
    logic             handoff_s;
    logic             valid_r;
    logic [15:0]      ctrl_r;
    logic [3:0]       mask_r;
    logic             illegal_r;
    logic [31:0]      instr_r;
    logic [CNT_W-1:0] cnt_r;

    // Decode of the incoming instruction, used for both capture and the HI/LO interlock.
    always_comb begin
        in_dec_s = decode(instr_in[31:26], instr_in[5:0]);
    end

    // Handshake: ready never looks at instr_valid_in except through the interlock.
    always_comb begin
        busy_s       = (cnt_r != CNT_ZERO);
        hazard_s     = busy_s & instr_valid_in & (in_dec_s.ctrl[14] | in_dec_s.ctrl[15]);
        base_ready_s = ~valid_r | ex_ready_in;
        ready_s      = base_ready_s & ~flush_in & ~hazard_s;
        accept_s     = instr_valid_in & ready_s;
        handoff_s    = valid_r & ex_ready_in;
    end

    // Entry valid flag: flush wins, then a new accept, then a plain handoff drains it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_r <= 1'b0;
        end else if (flush_in) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (handoff_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Entry payload: captured only on accept, otherwise held (stale while invalid).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ctrl_r    <= 16'h0000;
            mask_r    <= 4'h0;
            illegal_r <= 1'b0;
            instr_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            ctrl_r    <= in_dec_s.ctrl;
            mask_r    <= in_dec_s.mask;
            illegal_r <= in_dec_s.illegal;
            instr_r   <= instr_in;
        end else begin
            ctrl_r    <= ctrl_r;
            mask_r    <= mask_r;
            illegal_r <= illegal_r;
            instr_r   <= instr_r;
        end
    end

    // HI/LO busy counter: a mult/div leaving for EX reloads it, even under flush.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r <= CNT_ZERO;
        end else if (handoff_s && ctrl_r[14]) begin
            cnt_r <= CNT_LOAD;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign instr_ready_out = ready_s;
    assign ctrl_valid_out  = valid_r;
    assign ctrl_out        = ctrl_r;
    assign mmask_out       = mask_r;
    assign illegal_out     = illegal_r;
    assign instr_out       = instr_r;
    assign muldiv_busy_out = (cnt_r != CNT_ZERO);

endmodule
